alu_multicycle: RTL

//  Parametrised, handshaked successor to the single-cycle datapath ALU, for the multi-cycle RISC-V core.

---
 rtl/alu_multicycle.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle ALU for the EX stage: single-cycle logic/arith/shift ops
// plus iterative shift-add multiply and restoring divide (one bit per cycle).
//
// state | meaning
// IDLE  | waiting for a request; ready=1
// CALC  | iterative mul/divu/remu stepping; busy=1, ready=0
// DONE  | result valid this cycle (done=1); a new request may be accepted

module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             done,
  output logic             Zero,
  output logic             sign
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             iter_op;
  logic             last_step;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] single_res;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [SHW:0]     cnt;
  logic [3:0]       op_r;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign accept    = start & ready;
  assign last_step = (cnt == CNT_ONE);
  assign shamt     = SrcB[SHW-1:0];

  // Divide by zero skips iteration and takes the single-cycle path.
  assign iter_op = (ALUControl == OP_MUL) |
                   (((ALUControl == OP_DIVU) | (ALUControl == OP_REMU)) & (|SrcB));

  always_comb begin
    single_res = '0;
    case (ALUControl)
      OP_ADD:  single_res = SrcA + SrcB;
      OP_SUB:  single_res = SrcA - SrcB;
      OP_AND:  single_res = SrcA & SrcB;
      OP_OR:   single_res = SrcA | SrcB;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_XOR:  single_res = SrcA ^ SrcB;
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SLL:  single_res = SrcA << shamt;
      OP_SRL:  single_res = SrcA >> shamt;
      OP_SRA:  single_res = $signed(SrcA) >>> shamt;
      OP_DIVU: single_res = '1;
      OP_REMU: single_res = SrcA;
      default: single_res = '0;
    endcase
  end

  // One iteration step. Multiply: acc accumulates, xr = shifted multiplicand,
  // yr = shifted multiplier. Divide: acc = partial remainder, xr = dividend
  // shifting out / quotient shifting in, yr = divisor.
  always_comb begin
    mul_acc = acc + (yr[0] ? xr : '0);
    rem_sh  = {acc, xr[WIDTH-1]};
    diff    = rem_sh - {1'b0, yr};
    ge      = ~diff[WIDTH];
    rem_nxt = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt = {xr[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = iter_op ? CALC : DONE;
      end
      CALC: begin
        ready = 1'b0;
        busy  = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_nxt = iter_op ? CALC : DONE;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResult <= '0;
      acc       <= '0;
      xr        <= '0;
      yr        <= '0;
      cnt       <= '0;
      op_r      <= '0;
    end else if (accept) begin
      op_r <= ALUControl;
      if (iter_op) begin
        acc <= '0;
        xr  <= SrcA;
        yr  <= SrcB;
        cnt <= CNT_INIT;
      end else begin
        ALUResult <= single_res;
      end
    end else if (state == CALC) begin
      cnt <= cnt - CNT_ONE;
      if (op_r == OP_MUL) begin
        acc <= mul_acc;
        xr  <= {xr[WIDTH-2:0], 1'b0};
        yr  <= {1'b0, yr[WIDTH-1:1]};
      end else begin
        acc <= rem_nxt;
        xr  <= quo_nxt;
      end
      // The final step's value goes straight to the result register.
      if (last_step) begin
        if (op_r == OP_MUL)       ALUResult <= mul_acc;
        else if (op_r == OP_DIVU) ALUResult <= quo_nxt;
        else                      ALUResult <= rem_nxt;
      end
    end
  end

  assign Zero = ~|ALUResult;
  assign sign = ALUResult[WIDTH-1];

endmodule
